// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NRD    = 2;
    localparam int RF_NWR    = 2;

    // The reservation counter must represent 0..2**addr_w inclusive,
    // which needs one bit more than the address itself.
    function automatic int rf_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/rf_wr_arb.sv
// Write-port priority select: for one target address, reports whether any
// enabled write port hits it and returns the data of the highest-index hit.
module rf_wr_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NWR    = 2
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [NWR-1:0] match_s;

    for (genvar i = 0; i < NWR; i++) begin : g_match
        assign match_s[i] = wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == addr);
    end

    // Walk ports in ascending order so a later (higher-index) match overrides.
    always_comb begin
        hit  = 1'b0;
        data = {DATA_W{1'b0}};
        for (int i = 0; i < NWR; i++) begin
            hit  = hit | match_s[i];
            data = match_s[i] ? wr_data[i*DATA_W +: DATA_W] : data;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write bypass, optional hard-wired
// zero register and a per-register reservation (busy) scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NRD      = RF_NRD,
    parameter int NWR      = RF_NWR,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NRD*ADDR_W-1:0]         rd_addr,
    output logic [NRD*DATA_W-1:0]         rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR*ADDR_W-1:0]         wr_addr,
    input  logic [NWR*DATA_W-1:0]         wr_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [rf_cnt_w(ADDR_W)-1:0]   busy_cnt,
    output logic                          wr_conflict
);

    localparam int CNT_W = rf_cnt_w(ADDR_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0]             mem_r [DEPTH];
    logic [DEPTH-1:0]              busy_r;
    logic [CNT_W-1:0]              busy_cnt_r;

    logic [DEPTH-1:0]              ent_hit_s;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data_s;
    logic [DEPTH-1:0]              wr_eff_s;
    logic [DEPTH-1:0]              rsv_dec_s;
    logic [DEPTH-1:0]              busy_nxt_s;
    logic                          rsv_live_s;
    logic                          set_s;
    logic [CNT_W-1:0]              clr_s;
    logic [CNT_W-1:0]              cnt_nxt_s;

    // A reservation of register 0 is a no-op when it is hard-wired to zero.
    assign rsv_live_s = rsv_en && !(ZR && (rsv_addr == {ADDR_W{1'b0}}));

    // Commit path: one arbiter per storage entry picks the winning writer.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWR(NWR)) u_commit (
            .addr    (ADDR_W'(e)),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (ent_hit_s[e]),
            .data    (ent_data_s[e])
        );
        assign wr_eff_s[e]  = ent_hit_s[e] && !(ZR && (e == 0));
        assign rsv_dec_s[e] = rsv_live_s && (rsv_addr == ADDR_W'(e));
    end

    // Read path: bypass arbiter per read port, then zero-register override.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              byp_hit_s;
        logic [DATA_W-1:0] byp_data_s;
        logic              rd_zero_s;

        assign ra_s      = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_zero_s = ZR && (ra_s == {ADDR_W{1'b0}});

        rf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWR(NWR)) u_byp (
            .addr    (ra_s),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (byp_hit_s),
            .data    (byp_data_s)
        );

        assign rd_data[k*DATA_W +: DATA_W] = rd_zero_s ? {DATA_W{1'b0}} :
                                             (BP && byp_hit_s) ? byp_data_s : mem_r[ra_s];
        // A same-cycle write retires the reservation early unless a new
        // producer is reserving the same register in this very cycle.
        assign rd_busy[k] = !rd_zero_s && busy_r[ra_s] &&
                            !(BP && byp_hit_s && !(rsv_live_s && (rsv_addr == ra_s)));
    end

    // Collision detect: any pair of enabled ports targeting one live address.
    always_comb begin
        wr_conflict = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                wr_conflict = wr_conflict |
                    (wr_en[i] && wr_en[j] &&
                     (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]) &&
                     !(ZR && (wr_addr[i*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})));
            end
        end
    end

    // Next busy vector and counter deltas; a reservation beats a write clear.
    always_comb begin
        clr_s = {CNT_W{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
            busy_nxt_s[e] = rsv_dec_s[e] ? 1'b1 : (wr_eff_s[e] ? 1'b0 : busy_r[e]);
            clr_s = clr_s + CNT_W'(busy_r[e] & wr_eff_s[e] & ~rsv_dec_s[e]);
        end
        set_s     = rsv_live_s && !busy_r[rsv_addr];
        cnt_nxt_s = busy_cnt_r + CNT_W'(set_s) - clr_s;
    end

    // Storage commit; reset clears every entry immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_r[e] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_eff_s[e]) begin
                    mem_r[e] <= ent_data_s[e];
                end else begin
                    mem_r[e] <= mem_r[e];
                end
            end
        end
    end

    // Busy scoreboard and reserved-register count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
        end
    end

    assign busy_cnt = busy_cnt_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus a randomized
// phase, with expectations queued at stimulus time and compared mid-cycle.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    localparam int S_RD0 = 0, S_RD1 = 1, S_BZ0 = 2, S_BZ1 = 3, S_CNT = 4, S_CONF = 5;

    logic              clock;
    logic              reset_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [AW:0]       busy_cnt;
    logic              wr_conflict;

    reg_file_mp dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy_cnt    (busy_cnt),
        .wr_conflict (wr_conflict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] m_mem [32];
    logic        m_busy [32];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD0:   return rd_data[0 +: DW];
            S_RD1:   return rd_data[DW +: DW];
            S_BZ0:   return {31'd0, rd_busy[0]};
            S_BZ1:   return {31'd0, rd_busy[1]};
            S_CNT:   return {26'd0, busy_cnt};
            S_CONF:  return {31'd0, wr_conflict};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
        logic [31:0] v;
        v = m_mem[a];
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*DW +: DW];
        if (a == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic logic m_bz(input logic [AW-1:0] a);
        logic b;
        logic hit;
        b   = m_busy[a];
        hit = 1'b0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) hit = 1'b1;
        if (hit && !(rsv_en && rsv_addr == a)) b = 1'b0;
        if (a == 5'd0) b = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] m_cnt();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic m_conf();
        return (wr_en == 2'b11) && (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
               (wr_addr[0 +: AW] != 5'd0);
    endfunction

    task automatic m_update();
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0) begin
                m_mem[wr_addr[p*AW +: AW]]  = wr_data[p*DW +: DW];
                m_busy[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic push_model();
        push_exp("m_rd0",  S_RD0,  m_rd(rd_addr[0 +: AW]));
        push_exp("m_rd1",  S_RD1,  m_rd(rd_addr[AW +: AW]));
        push_exp("m_bz0",  S_BZ0,  {31'd0, m_bz(rd_addr[0 +: AW])});
        push_exp("m_bz1",  S_BZ1,  {31'd0, m_bz(rd_addr[AW +: AW])});
        push_exp("m_cnt",  S_CNT,  m_cnt());
        push_exp("m_conf", S_CONF, {31'd0, m_conf()});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    // One clock: queue model expectations, compare mid-cycle, commit at edge.
    task automatic cycle();
        push_model();
        @(negedge clock);
        drain();
        @(posedge clock);
        if (reset_n) m_update();
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 2'b00;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = 5'd0;
        rd_addr  = '0;
        m_reset();
        set_rd(5'd5, 5'd9);
        #12;
        push_exp("rst_rd0", S_RD0, 32'd0);
        push_exp("rst_rd1", S_RD1, 32'd0);
        push_exp("rst_bz0", S_BZ0, 32'd0);
        push_exp("rst_cnt", S_CNT, 32'd0);
        drain();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Write r5 on port 0, read it back on both ports next cycle.
        set_wr(0, 5'd5, 32'h1234_5678);
        cycle();
        idle();
        set_rd(5'd5, 5'd5);
        push_exp("r5_p0", S_RD0, 32'h1234_5678);
        push_exp("r5_p1", S_RD1, 32'h1234_5678);
        cycle();

        // Colliding writes to r7: highest port wins both bypass and storage.
        set_wr(0, 5'd7, 32'd11);
        set_wr(1, 5'd7, 32'd22);
        set_rd(5'd7, 5'd5);
        push_exp("conf_r7", S_CONF, 32'd1);
        push_exp("byp_r7",  S_RD0,  32'd22);
        cycle();
        idle();
        push_exp("conf_idle", S_CONF, 32'd0);
        push_exp("store_r7",  S_RD0,  32'd22);
        cycle();

        // Register 0 ignores writes and reservations.
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_wr(1, 5'd0, 32'hFFFF_FFFF);
        set_rsv(5'd0);
        set_rd(5'd0, 5'd7);
        push_exp("r0_byp",  S_RD0,  32'd0);
        push_exp("r0_busy", S_BZ0,  32'd0);
        push_exp("r0_conf", S_CONF, 32'd0);
        cycle();
        idle();
        push_exp("r0_rd",  S_RD0, 32'd0);
        push_exp("r0_cnt", S_CNT, 32'd0);
        cycle();

        // Reservation counting, write clears, write+reserve keeps busy.
        set_rsv(5'd3);
        cycle();
        set_rsv(5'd4);
        cycle();
        idle();
        set_rd(5'd3, 5'd4);
        push_exp("cnt_2",   S_CNT, 32'd2);
        push_exp("bz_r3",   S_BZ0, 32'd1);
        cycle();
        set_wr(0, 5'd3, 32'h0000_0033);
        push_exp("bz_r3_byp", S_BZ0, 32'd0);
        cycle();
        idle();
        set_wr(1, 5'd4, 32'h0000_0044);
        set_rsv(5'd4);
        set_rd(5'd3, 5'd4);
        push_exp("cnt_1",     S_CNT, 32'd1);
        push_exp("bz_r4_rsv", S_BZ1, 32'd1);
        cycle();
        idle();
        push_exp("cnt_1b",  S_CNT, 32'd1);
        push_exp("bz_r4",   S_BZ1, 32'd1);
        push_exp("rd_r4",   S_RD1, 32'h0000_0044);
        push_exp("rd_r3",   S_RD0, 32'h0000_0033);
        cycle();

        // Randomized traffic over a narrow address range to force overlaps.
        for (int it = 0; it < 80; it++) begin
            idle();
            for (int p = 0; p < NWR; p++)
                if ($urandom_range(0, 1) == 1) set_wr(p, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) set_rsv(5'($urandom_range(0, 7)));
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        // Asynchronous reset between edges clears everything at once.
        idle();
        set_rsv(5'd9);
        cycle();
        idle();
        set_rd(5'd5, 5'd9);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        push_exp("arst_cnt", S_CNT, 32'd0);
        push_exp("arst_rd0", S_RD0, 32'd0);
        push_exp("arst_bz1", S_BZ1, 32'd0);
        drain();
        // Writes and reservations presented while in reset are discarded.
        set_wr(0, 5'd5, 32'hAAAA_5555);
        set_rsv(5'd6);
        @(posedge clock);
        #1;
        idle();
        #2;
        reset_n = 1'b1;
        set_rd(5'd5, 5'd6);
        push_exp("post_rd5", S_RD0, 32'd0);
        push_exp("post_bz6", S_BZ1, 32'd0);
        push_exp("post_cnt", S_CNT, 32'd0);
        cycle();
        set_wr(0, 5'd5, 32'h0BAD_F00D);
        cycle();
        idle();
        push_exp("post_wr5", S_RD0, 32'h0BAD_F00D);
        cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DATA_W  32  register width in bits
  ADDR_W  5  address width; depth = 2**ADDR_W
  NRD  2  number of read ports
  NWR  2  number of write ports
  ZERO_REG  1  when 1, register 0 reads 0 and ignores writes and reservations
  BYPASS  1  when 1, same-cycle writes forward to reads
REQ-002 Ports, one per line (name, direction, width, meaning):
  clock  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  rd_addr  in  NRD*ADDR_W  read addresses; port k in slice k
  rd_data  out  NRD*DATA_W  read data; port k in slice k
  rd_busy  out  NRD  port k address has a pending reservation
  wr_en  in  NWR  write enable per write port
  wr_addr  in  NWR*ADDR_W  write addresses
  wr_data  in  NWR*DATA_W  write data, signed two's complement
  rsv_en  in  1  reserve a destination register (issue stage)
  rsv_addr  in  ADDR_W  register to reserve
  busy_cnt  out  ADDR_W+1  number of registers currently reserved
  wr_conflict  out  1  pulse: two or more enabled write ports hit the same address this cycle
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 Reads SHALL be combinational (zero-cycle latency) from storage, except as REQ-005 and REQ-006 specify.
REQ-005 With ZERO_REG=1, a read of address 0 SHALL return 0 and rd_busy=0, regardless of writes or reservations.
REQ-006 With BYPASS=1, a read whose address matches an enabled write port in the same cycle SHALL return that port's wr_data; on multiple matches, the highest-index port wins.
REQ-007 Writes SHALL commit on the rising clock edge; when several enabled ports hit one address, the highest-index port's data SHALL be stored.
REQ-008 wr_conflict SHALL be a combinational indication of REQ-007 collisions, suppressed for address 0 when ZERO_REG=1.
REQ-009 Busy vector: rsv_en sets busy[rsv_addr] at the clock edge; any enabled write to an address clears its busy bit at the edge.
REQ-010 Reservation and write to the same address in one cycle: the data SHALL be written and busy SHALL end set (the new producer wins).
REQ-011 Reservation of an already busy register SHALL leave it busy and SHALL NOT change busy_cnt.
REQ-012 rd_busy[k] SHALL reflect the registered busy bit, cleared combinationally when BYPASS=1 and a same-cycle write matches, unless rsv_en targets that address.
REQ-013 busy_cnt SHALL be a register updated each edge by +1 (new set), -1 per cleared bit, and net 0 otherwise; it SHALL never wrap because its range covers 0..2**ADDR_W.
REQ-014 With ZERO_REG=1, writes and reservations to address 0 SHALL have no effect.

Reset
REQ-015 reset_n low SHALL immediately clear all registers, all busy bits, and busy_cnt to 0, independent of clock.
REQ-016 A reset asserted mid-operation SHALL discard same-cycle writes and reservations; the first edge after deassertion SHALL behave normally.
REQ-017 After reset, rd_data=0, rd_busy=0, busy_cnt=0, and wr_conflict is driven only by current inputs.

Structure
REQ-018 The shared package rf_pkg SHALL hold the default DATA_W, ADDR_W, NRD, and NWR constants and a function that computes the busy_cnt width.
REQ-019 Write-port priority select SHALL be a sub-module rf_wr_arb, instantiated once per read port for bypass and once per storage entry for commit.

Verification
REQ-020 Reset, then write 32'h1234_5678 to r5 via port 0; next cycle read r5 on both read ports -> both return 32'h1234_5678.
REQ-021 Same cycle: port 0 writes 11 to r7 and port 1 writes 22 to r7 -> wr_conflict=1; bypass read returns 22; stored value is 22.
REQ-022 Write 32'hFFFF_FFFF to r0 and reserve r0 -> r0 reads 0, rd_busy=0, busy_cnt stays 0.
REQ-023 Reserve r3, then r4 -> busy_cnt=2; write r3 -> busy_cnt=1; write r4 while reserving r4 in the same cycle -> busy_cnt=1 and r4 stays busy.
REQ-024 Reserve r9, then assert reset_n low between edges -> busy_cnt and all data are 0 at once, before the next edge.
